// File: rtl/dual_osc_pkg.sv
// rtl/dual_osc_pkg.sv - shared types and constants for the dual oscillator meter
package dual_osc_pkg;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      SETTLE  = 2'd1,
      MEASURE = 2'd2,
      DONE    = 2'd3
   } state_t;

   localparam logic CH_A = 1'b0;
   localparam logic CH_B = 1'b1;

   localparam int DEF_CNT_W  = 16;
   localparam int DEF_GATE_W = 16;

endpackage

// File: rtl/osc_edge_counter.sv
// rtl/osc_edge_counter.sv - synchronizes an async oscillator and counts its rising edges
module osc_edge_counter
   import dual_osc_pkg::*;
#(
   parameter int CNT_W = DEF_CNT_W
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             clear,
   input  logic             count_en,
   input  logic             async_in,
   output logic [CNT_W-1:0] count,
   output logic             ovf
);

   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   logic sync_1;
   logic sync_2;
   logic prev;
   logic edge_seen;

   assign edge_seen = sync_2 & ~prev;

   // prev follows sync_2 every cycle, so a clear never sees a stale level as an edge
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sync_1 <= 1'b0;
         sync_2 <= 1'b0;
         prev   <= 1'b0;
         count  <= '0;
         ovf    <= 1'b0;
      end else begin
         sync_1 <= async_in;
         sync_2 <= sync_1;
         prev   <= sync_2;
         if (clear) begin
            count <= '0;
            ovf   <= 1'b0;
         end else if (count_en && edge_seen) begin
            if (count == CNT_MAX) begin
               ovf <= 1'b1;
            end else begin
               count <= count + 1'b1;
            end
         end
      end
   end

endmodule

// File: rtl/dual_osc_meter_ctrl.sv
// rtl/dual_osc_meter_ctrl.sv - sequences A/B oscillator settle, gated edge count and result handshake
module dual_osc_meter_ctrl
   import dual_osc_pkg::*;
#(
   parameter int CNT_W         = DEF_CNT_W,
   parameter int GATE_W        = DEF_GATE_W,
   parameter int SETTLE_CYCLES = 8
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic              continuous,
   input  logic [GATE_W-1:0] gate_len,
   input  logic              osc_a,
   input  logic              osc_b,
   output logic              osc_en_a,
   output logic              osc_en_b,
   output logic              busy,
   output logic              res_valid,
   input  logic              res_ready,
   output logic              res_chan,
   output logic [CNT_W-1:0]  res_count,
   output logic              res_ovf
);

   localparam int SW = $clog2(SETTLE_CYCLES);
   localparam logic [SW-1:0] SETTLE_LAST = SW'(SETTLE_CYCLES - 1);

   state_t            state;
   logic              chan;
   logic [SW-1:0]     settle_cnt;
   logic [GATE_W-1:0] gate_left;
   logic              sel_osc;
   logic              settle_done;
   logic              gate_last;
   logic              count_en;

   assign sel_osc     = (chan == CH_B) ? osc_b : osc_a;
   assign settle_done = (state == SETTLE) && (settle_cnt == SETTLE_LAST);
   assign gate_last   = (gate_left == '0) || (gate_left == GATE_W'(1));
   // a zero gate still spends one MEASURE cycle, but must not count in it
   assign count_en    = (state == MEASURE) && (gate_left != '0);
   assign res_chan    = chan;

   osc_edge_counter #(
      .CNT_W(CNT_W)
   ) u_counter (
      .clk      (clk),
      .rst      (rst),
      .clear    (settle_done),
      .count_en (count_en),
      .async_in (sel_osc),
      .count    (res_count),
      .ovf      (res_ovf)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state      <= IDLE;
         chan       <= CH_A;
         busy       <= 1'b0;
         osc_en_a   <= 1'b0;
         osc_en_b   <= 1'b0;
         res_valid  <= 1'b0;
         settle_cnt <= '0;
         gate_left  <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (start) begin
                  state      <= SETTLE;
                  chan       <= CH_A;
                  busy       <= 1'b1;
                  osc_en_a   <= 1'b1;
                  osc_en_b   <= 1'b0;
                  settle_cnt <= '0;
               end
            end
            SETTLE: begin
               if (settle_done) begin
                  state     <= MEASURE;
                  gate_left <= gate_len;
               end else begin
                  settle_cnt <= settle_cnt + 1'b1;
               end
            end
            MEASURE: begin
               if (gate_last) begin
                  state     <= DONE;
                  osc_en_a  <= 1'b0;
                  osc_en_b  <= 1'b0;
                  res_valid <= 1'b1;
               end else begin
                  gate_left <= gate_left - 1'b1;
               end
            end
            DONE: begin
               if (res_ready) begin
                  res_valid  <= 1'b0;
                  settle_cnt <= '0;
                  if (chan == CH_A) begin
                     state    <= SETTLE;
                     chan     <= CH_B;
                     osc_en_b <= 1'b1;
                  end else if (continuous) begin
                     state    <= SETTLE;
                     chan     <= CH_A;
                     osc_en_a <= 1'b1;
                  end else begin
                     state <= IDLE;
                     busy  <= 1'b0;
                  end
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_dual_osc_meter_ctrl.sv
// tb/tb_dual_osc_meter_ctrl.sv - self-checking bench for dual_osc_meter_ctrl
module tb_dual_osc_meter_ctrl;

   localparam int S   = 8;
   localparam int CW  = 16;
   localparam int SCW = 4;
   localparam int GW  = 16;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          start = 1'b0;
   logic          continuous = 1'b0;
   logic [GW-1:0] gate_len = '0;
   logic          osc_a = 1'b0;
   logic          osc_b = 1'b0;
   logic          res_ready = 1'b1;

   logic          osc_en_a, osc_en_b, busy, res_valid, res_chan, res_ovf;
   logic [CW-1:0] res_count;
   logic          s_osc_en_a, s_osc_en_b, s_busy, s_res_valid, s_res_chan, s_res_ovf;
   logic [SCW-1:0] s_res_count;

   dual_osc_meter_ctrl #(.CNT_W(CW), .GATE_W(GW), .SETTLE_CYCLES(S)) dut (
      .clk(clk), .rst(rst), .start(start), .continuous(continuous), .gate_len(gate_len),
      .osc_a(osc_a), .osc_b(osc_b), .osc_en_a(osc_en_a), .osc_en_b(osc_en_b), .busy(busy),
      .res_valid(res_valid), .res_ready(res_ready), .res_chan(res_chan),
      .res_count(res_count), .res_ovf(res_ovf));

   dual_osc_meter_ctrl #(.CNT_W(SCW), .GATE_W(GW), .SETTLE_CYCLES(S)) dut_sat (
      .clk(clk), .rst(rst), .start(start), .continuous(continuous), .gate_len(gate_len),
      .osc_a(osc_a), .osc_b(osc_b), .osc_en_a(s_osc_en_a), .osc_en_b(s_osc_en_b), .busy(s_busy),
      .res_valid(s_res_valid), .res_ready(res_ready), .res_chan(s_res_chan),
      .res_count(s_res_count), .res_ovf(s_res_ovf));

   always #5 clk = ~clk;

   int pa = 10;
   int pb = 4;
   int cyc = 0;

   // square waves with one rising edge per period, changed away from clk edges
   initial begin
      forever begin
         @(posedge clk);
         #2;
         cyc++;
         osc_a = ((cyc % pa) < (pa / 2));
         osc_b = ((cyc % pb) < (pb / 2));
      end
   end

   int n_chk = 0;
   int n_fail = 0;
   int overlap = 0;
   int run_a = 0;
   int run_b = 0;
   int len_a[$];
   int len_b[$];

   always @(negedge clk) begin
      if ((osc_en_a && osc_en_b) || (s_osc_en_a && s_osc_en_b)) overlap++;
      if (osc_en_a) run_a++;
      else if (run_a != 0) begin len_a.push_back(run_a); run_a = 0; end
      if (osc_en_b) run_b++;
      else if (run_b != 0) begin len_b.push_back(run_b); run_b = 0; end
   end

   task automatic check(input string name, input longint act, input longint exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   // reference: an exactly periodic input gives gate/period edges in any window
   function automatic int exp_cnt(input int g, input int p, input int w);
      int e = g / p;
      int mx = (1 << w) - 1;
      return (e > mx) ? mx : e;
   endfunction

   function automatic int exp_ovf(input int g, input int p, input int w);
      return ((g / p) > ((1 << w) - 1)) ? 1 : 0;
   endfunction

   function automatic int exp_lat(input int g);
      return S + ((g == 0) ? 1 : g) + 1;
   endfunction

   task automatic wait_valid(output int lat);
      lat = 0;
      do begin
         @(negedge clk);
         start = 1'b0;
         lat++;
      end while (!res_valid && lat < 5000);
      if (!res_valid) check("valid_timeout", 0, 1);
   endtask

   task automatic check_zero(input string tag);
      check({tag, "_busy"}, busy, 0);
      check({tag, "_en_a"}, osc_en_a, 0);
      check({tag, "_en_b"}, osc_en_b, 0);
      check({tag, "_valid"}, res_valid, 0);
      check({tag, "_chan"}, res_chan, 0);
      check({tag, "_count"}, res_count, 0);
      check({tag, "_ovf"}, res_ovf, 0);
   endtask

   task automatic run_pair(input int g, input int a, input int b, input int ea, input int eb,
                           input int sea, input int soa, input int seb, input int sob);
      int lat;
      gate_len = GW'(g); pa = a; pb = b; res_ready = 1'b1; continuous = 1'b0;
      @(negedge clk);
      start = 1'b1;
      wait_valid(lat);
      check("a_latency", lat, exp_lat(g));
      check("a_chan", res_chan, 0);
      check("a_count", res_count, ea);
      check("a_ovf", res_ovf, 0);
      check("sat_a_valid", s_res_valid, 1);
      check("sat_a_count", s_res_count, sea);
      check("sat_a_ovf", s_res_ovf, soa);
      wait_valid(lat);
      check("b_latency", lat, exp_lat(g));
      check("b_chan", res_chan, 1);
      check("b_count", res_count, eb);
      check("b_ovf", res_ovf, 0);
      check("sat_b_count", s_res_count, seb);
      check("sat_b_ovf", s_res_ovf, sob);
      @(negedge clk);
      check("idle_busy", busy, 0);
      check("en_a_len", (len_a.size() > 0) ? len_a[$] : -1, S + ((g == 0) ? 1 : g));
      check("en_b_len", (len_b.size() > 0) ? len_b[$] : -1, S + ((g == 0) ? 1 : g));
   endtask

   typedef struct {
      int g; int a; int b;
      int ea; int eb; int sea; int soa; int seb; int sob;
   } vec_t;

   vec_t tbl[5];

   initial begin
      int lat, g, a, b, k, nres, since, bad;
      int chans[$];
      logic stuck;

      tbl[0] = '{100, 10, 4, 10, 25, 10, 0, 15, 1};
      tbl[1] = '{0,   5,  3, 0,  0,  0,  0, 0,  0};
      tbl[2] = '{20,  5,  2, 4,  10, 4,  0, 10, 0};
      tbl[3] = '{6,   3,  2, 2,  3,  2,  0, 3,  0};
      tbl[4] = '{64,  2,  4, 32, 16, 15, 1, 15, 1};

      repeat (3) @(negedge clk);
      check_zero("reset");
      rst = 1'b0;
      repeat (2) @(negedge clk);

      foreach (tbl[i])
         run_pair(tbl[i].g, tbl[i].a, tbl[i].b, tbl[i].ea, tbl[i].eb,
                  tbl[i].sea, tbl[i].soa, tbl[i].seb, tbl[i].sob);

      for (int r = 0; r < 6; r++) begin
         a = $urandom_range(2, 8);
         b = $urandom_range(2, 8);
         k = $urandom_range(1, 3);
         g = k * a * b;
         run_pair(g, a, b, exp_cnt(g, a, CW), exp_cnt(g, b, CW),
                  exp_cnt(g, a, SCW), exp_ovf(g, a, SCW), exp_cnt(g, b, SCW), exp_ovf(g, b, SCW));
      end

      // backpressure on the A result
      gate_len = 100; pa = 10; pb = 4; res_ready = 1'b0;
      @(negedge clk);
      start = 1'b1;
      wait_valid(lat);
      stuck = 1'b1;
      for (int t = 0; t < 50; t++) begin
         @(negedge clk);
         if (!res_valid || res_count != 10 || osc_en_b || res_chan) stuck = 1'b0;
      end
      check("bp_hold", stuck, 1);
      res_ready = 1'b1;
      @(negedge clk);
      check("bp_valid_drop", res_valid, 0);
      check("bp_en_b_rise", osc_en_b, 1);
      wait_valid(lat);
      check("bp_b_chan", res_chan, 1);
      check("bp_b_count", res_count, 25);
      @(negedge clk);

      // continuous mode, cleared during the third A, with an ignored start while busy
      gate_len = 20; pa = 5; pb = 4; continuous = 1'b1; res_ready = 1'b1;
      @(negedge clk);
      start = 1'b1;
      nres = 0; since = -1; bad = 0;
      for (int t = 0; t < 3000; t++) begin
         @(negedge clk);
         start = (t == 40);
         if (res_valid) begin
            chans.push_back(int'(res_chan));
            if (res_count != (((nres % 2) == 1) ? 5 : 4)) bad++;
            nres++;
            if (nres == 4) since = 0;
         end
         if (since >= 0) begin
            since++;
            if (since == S + 5) continuous = 1'b0;
         end
         if (!busy) break;
      end
      start = 1'b0;
      check("cont_nres", nres, 6);
      check("cont_counts", bad, 0);
      foreach (chans[i]) check("cont_seq", chans[i], i % 2);
      stuck = 1'b0;
      for (int t = 0; t < 50; t++) begin
         @(negedge clk);
         if (res_valid || busy) stuck = 1'b1;
      end
      check("cont_no_extra", stuck, 0);

      // async reset during MEASURE
      gate_len = 100; pa = 10; pb = 4;
      @(negedge clk);
      start = 1'b1;
      repeat (S + 40) begin @(negedge clk); start = 1'b0; end
      check("pre_rst_count", res_count > 0, 1);
      #1 rst = 1'b1;
      #1 check_zero("rst_measure");
      @(negedge clk);
      rst = 1'b0;
      stuck = 1'b0;
      for (int t = 0; t < 20; t++) begin
         @(negedge clk);
         if (res_valid || busy) stuck = 1'b1;
      end
      check("rst_measure_quiet", stuck, 0);
      run_pair(100, 10, 4, 10, 25, 10, 0, 15, 1);

      // async reset while a result is pending
      res_ready = 1'b0;
      @(negedge clk);
      start = 1'b1;
      wait_valid(lat);
      #1 rst = 1'b1;
      #1 check_zero("rst_done");
      @(negedge clk);
      rst = 1'b0;
      repeat (3) @(negedge clk);
      check("rst_done_quiet", res_valid, 0);
      run_pair(20, 5, 2, 4, 10, 4, 0, 10, 0);

      check("no_overlap", overlap, 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
